// File: rtl/cp_tx_arbiter.sv
// Four-requester transmit arbiter: round-robin grant, RTS/CTS handshake over the control channel, then data burst.
// Optional CP_ARB_STATS_EN adds a saturating transferred-word counter output (word_count).
module cp_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] node_id,
  input  logic [15:0] max_node,
  input  logic [3:0]  req,
  input  logic [63:0] req_dest,
  input  logic [63:0] req_len,
  input  logic [3:0]  data_valid,
  input  logic [63:0] data_in,
  input  logic [31:0] control_rx_packet,
  output logic [3:0]  grant,
  output logic [3:0]  data_ready,
  output logic [31:0] control_tx_packet,
  output logic [31:0] data_tx_packet,
  output logic        busy,
  output logic        reject,
  output logic        timeout_err
`ifdef CP_ARB_STATS_EN
  ,
  output logic [15:0] word_count
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RTS      = 3'd1,
    WAIT_CTS = 3'd2,
    SEND     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  ptr_r, ptr_s;
  logic [1:0]  win_r, win_s;
  logic [1:0]  pick_s;
  logic [15:0] dest_r, dest_s;
  logic [15:0] len_r, len_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [15:0] rem_r, rem_s;
  logic [3:0]  grant_s;
  logic [3:0]  ready_s;
  logic [31:0] ctl_tx_s;
  logic [31:0] data_tx_s;
  logic        reject_s;
  logic        timeout_s;
  logic        cts_s;
  logic        invalid_s;
  logic        xfer_s;

  // First requester found scanning upward from p+1, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = p;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx   = p + 2'(i);
      sel   = (!found && r[idx]) ? idx : sel;
      found = found | r[idx];
    end
    return sel;
  endfunction

  assign pick_s    = rr_pick(req, ptr_r);
  assign cts_s     = (control_rx_packet == {node_id, 16'hFFFF});
  assign invalid_s = (dest_r == node_id) || (dest_r >= max_node) || (len_r == 16'd0);
  assign xfer_s    = (state_r == SEND) && data_valid[win_r];

  // Next-state and next-output decode for the arbitration FSM.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    win_s     = win_r;
    dest_s    = dest_r;
    len_s     = len_r;
    cnt_s     = cnt_r;
    rem_s     = rem_r;
    grant_s   = grant;
    ready_s   = 4'b0000;
    ctl_tx_s  = 32'h0000_0000;
    data_tx_s = 32'h0000_0000;
    reject_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          win_s   = pick_s;
          grant_s = 4'b0001 << pick_s;
          dest_s  = req_dest[{pick_s, 4'b0000} +: 16];
          len_s   = req_len[{pick_s, 4'b0000} +: 16];
          state_s = RTS;
        end else begin
          grant_s = 4'b0000;
        end
      end
      RTS: begin
        if (invalid_s) begin
          reject_s = 1'b1;
          ptr_s    = win_r;
          grant_s  = 4'b0000;
          state_s  = IDLE;
        end else begin
          ctl_tx_s = {dest_r, len_r};
          cnt_s    = 8'(TIMEOUT_CYCLES);
          state_s  = WAIT_CTS;
        end
      end
      WAIT_CTS: begin
        // A dropped request outranks a CTS arriving in the same cycle.
        if (!req[win_r]) begin
          ptr_s   = win_r;
          grant_s = 4'b0000;
          cnt_s   = 8'd0;
          state_s = IDLE;
        end else if (cts_s) begin
          rem_s   = len_r;
          ready_s = grant;
          cnt_s   = 8'd0;
          state_s = SEND;
        end else if (cnt_r <= 8'd1) begin
          timeout_s = 1'b1;
          ptr_s     = win_r;
          grant_s   = 4'b0000;
          cnt_s     = 8'd0;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      SEND: begin
        if (data_valid[win_r]) begin
          data_tx_s = {dest_r, data_in[{win_r, 4'b0000} +: 16]};
          rem_s     = rem_r - 16'd1;
          if (rem_r == 16'd1) begin
            grant_s = 4'b0000;
            state_s = DONE;
          end else begin
            ready_s = grant;
          end
        end else begin
          ready_s = grant;
        end
      end
      DONE: begin
        ptr_s   = win_r;
        grant_s = 4'b0000;
        state_s = IDLE;
      end
      default: begin
        grant_s = 4'b0000;
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      ptr_r             <= 2'd3;
      win_r             <= 2'd0;
      dest_r            <= 16'd0;
      len_r             <= 16'd0;
      cnt_r             <= 8'd0;
      rem_r             <= 16'd0;
      grant             <= 4'b0000;
      data_ready        <= 4'b0000;
      control_tx_packet <= 32'h0000_0000;
      data_tx_packet    <= 32'h0000_0000;
      busy              <= 1'b0;
      reject            <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      state_r           <= state_s;
      ptr_r             <= ptr_s;
      win_r             <= win_s;
      dest_r            <= dest_s;
      len_r             <= len_s;
      cnt_r             <= cnt_s;
      rem_r             <= rem_s;
      grant             <= grant_s;
      data_ready        <= ready_s;
      control_tx_packet <= ctl_tx_s;
      data_tx_packet    <= data_tx_s;
      busy              <= (state_s != IDLE);
      reject            <= reject_s;
      timeout_err       <= timeout_s;
    end
  end

`ifdef CP_ARB_STATS_EN
  // Saturating count of words moved onto the data channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= 16'd0;
    end else if (xfer_s && (word_count != 16'hFFFF)) begin
      word_count <= word_count + 16'd1;
    end else begin
      word_count <= word_count;
    end
  end
`endif

endmodule
